// File: rtl/chip_id_reader_if.sv
// Fuse shift-register link and ID result signals of chip_id_reader.
// master = the reader, slave = the fuse block / ID consumer.
interface chip_id_reader_if;
   logic        fuse_clk_o;
   logic        fuse_shiftnld_o;
   logic        fuse_dout_i;
   logic        data_valid;
   logic [63:0] chip_id;
   logic        id_error;

   modport master (
      output fuse_clk_o, fuse_shiftnld_o, data_valid, chip_id, id_error,
      input  fuse_dout_i
   );

   modport slave (
      input  fuse_clk_o, fuse_shiftnld_o, data_valid, chip_id, id_error,
      output fuse_dout_i
   );
endinterface

// File: rtl/chip_id_reader.sv
// Reads the 64-bit on-die fuse ID once after reset: LOAD pulses, then 64 SHIFT pulses, LSB first.
// Optional macro CHIP_ID_DOUBLE_READ_EN: two passes per attempt, compared, retried up to MAX_RETRY.
module chip_id_reader #(
   parameter int LOAD_PULSES = 2,
   parameter int MAX_RETRY   = 3
) (
   input  logic             clkin,
   input  logic             reset,
   chip_id_reader_if.master bus
);
   localparam int               CNT_W      = 16;
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(2 * LOAD_PULSES - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(127);

`ifdef CHIP_ID_DOUBLE_READ_EN
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   typedef enum logic [2:0] {
      IDLE = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, COMPARE = 3'd3, DONE = 3'd4, FAIL = 3'd5
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fuse_clk_q, fuse_clk_d;
   logic             shiftnld_q, shiftnld_d;
   logic             valid_q, valid_d;
   logic [63:0]      cap_q, cap_d;
   logic [63:0]      chip_id_q, chip_id_d;
`ifdef CHIP_ID_DOUBLE_READ_EN
   logic [63:0]      a_q, a_d;
   logic [63:0]      b_q, b_d;
   logic             pass_q, pass_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             err_q, err_d;
`endif

   // Next-state, capture and registered-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      cap_d     = cap_q;
      chip_id_d = chip_id_q;
      valid_d   = valid_q;
`ifdef CHIP_ID_DOUBLE_READ_EN
      a_d       = a_q;
      b_d       = b_q;
      pass_d    = pass_q;
      retry_d   = retry_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
         LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               state_d = LOAD;
            end
         end
         SHIFT: begin
            // odd count = fuse clock high; this edge ends the high phase
            if (cnt_q[0]) begin
               cap_d = {bus.fuse_dout_i, cap_q[63:1]};
            end else begin
               cap_d = cap_q;
            end
            if (cnt_q == SHIFT_LAST) begin
               cnt_d = '0;
`ifdef CHIP_ID_DOUBLE_READ_EN
               if (!pass_q) begin
                  a_d     = cap_d;
                  pass_d  = 1'b1;
                  state_d = LOAD;
               end else begin
                  b_d     = cap_d;
                  pass_d  = 1'b0;
                  state_d = COMPARE;
               end
`else
               state_d   = DONE;
               chip_id_d = cap_d;
               valid_d   = 1'b1;
`endif
            end else begin
               state_d = SHIFT;
            end
         end
`ifdef CHIP_ID_DOUBLE_READ_EN
         COMPARE: begin
            cnt_d = '0;
            if (a_q == b_q) begin
               state_d   = DONE;
               chip_id_d = a_q;
               valid_d   = 1'b1;
            end else if (retry_q == RTY_W'(MAX_RETRY)) begin
               state_d = FAIL;
               err_d   = 1'b1;
            end else begin
               state_d = LOAD;
               retry_d = retry_q + RTY_W'(1);
            end
         end
         FAIL: begin
            cnt_d = cnt_q;
         end
`endif
         DONE: begin
            cnt_d = cnt_q;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      fuse_clk_d = ((state_d == LOAD) || (state_d == SHIFT)) && cnt_d[0];
      shiftnld_d = (state_d == SHIFT);
   end

   // State and output registers
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         fuse_clk_q <= 1'b0;
         shiftnld_q <= 1'b0;
         valid_q    <= 1'b0;
         cap_q      <= 64'h0;
         chip_id_q  <= 64'h0;
`ifdef CHIP_ID_DOUBLE_READ_EN
         a_q        <= 64'h0;
         b_q        <= 64'h0;
         pass_q     <= 1'b0;
         retry_q    <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fuse_clk_q <= fuse_clk_d;
         shiftnld_q <= shiftnld_d;
         valid_q    <= valid_d;
         cap_q      <= cap_d;
         chip_id_q  <= chip_id_d;
`ifdef CHIP_ID_DOUBLE_READ_EN
         a_q        <= a_d;
         b_q        <= b_d;
         pass_q     <= pass_d;
         retry_q    <= retry_d;
         err_q      <= err_d;
`endif
      end
   end

   assign bus.fuse_clk_o      = fuse_clk_q;
   assign bus.fuse_shiftnld_o = shiftnld_q;
   assign bus.data_valid      = valid_q;
   assign bus.chip_id         = chip_id_q;
`ifdef CHIP_ID_DOUBLE_READ_EN
   assign bus.id_error        = err_q;
`else
   assign bus.id_error        = 1'b0;
`endif
endmodule

// File: tb/tb_chip_id_reader.sv
// Scoreboard bench for chip_id_reader: behavioural fuse model, expected results queued per read,
// monitor compares on data_valid / id_error rising. Double-read cases run when the macro is defined.
module tb_chip_id_reader;
   localparam int LP       = 2;
   localparam int MR       = 3;
   localparam int PASS_CYC = 2 * LP + 128;

   typedef struct {
      logic        fail;
      logic [63:0] id;
      int          edge_n;
   } exp_t;

   logic clkin = 1'b0;
   logic reset = 1'b0;
   chip_id_reader_if bus ();

   chip_id_reader #(.LOAD_PULSES(LP), .MAX_RETRY(MR)) dut (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clkin = ~clkin;

   int   errors   = 0;
   int   checks   = 0;
   int   resolved = 0;
   int   edge_n   = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Fuse block model: values handed out one per pass, shifted LSB first
   logic [63:0] pass_vals [16];
   logic [63:0] sr;
   logic        mode_shift;
   logic        in_load;
   int          pass_idx;
   int          load_pulses;
   int          shift_pulses;
   assign bus.fuse_dout_i = sr[0];

   always @(posedge bus.fuse_clk_o or negedge bus.fuse_clk_o or posedge reset) begin
      if (reset) begin
         sr = 64'h0; mode_shift = 1'b0; in_load = 1'b0;
         pass_idx = 0; load_pulses = 0; shift_pulses = 0;
      end else if (bus.fuse_clk_o) begin
         mode_shift = bus.fuse_shiftnld_o;
         if (bus.fuse_shiftnld_o) begin
            shift_pulses++;
            in_load = 1'b0;
         end else begin
            load_pulses++;
            if (!in_load) begin
               in_load = 1'b1;
               pass_idx++;
            end
            sr = pass_vals[(pass_idx - 1) % 16];
         end
      end else if (mode_shift) begin
         sr = sr >> 1;
      end
   end

   always @(posedge clkin) begin
      if (reset) edge_n <= 0;
      else       edge_n <= edge_n + 1;
   end

   // Monitor: zero outputs in reset, chip_id hidden until valid, scoreboard pop on result
   logic prev_valid = 1'b0;
   logic prev_err   = 1'b0;
   exp_t mon_e;
   always @(posedge clkin) begin
      #1;
      if (reset) begin
         chk("reset_outputs", {59'h0, bus.fuse_clk_o, bus.fuse_shiftnld_o, bus.data_valid,
             bus.id_error, |bus.chip_id}, 64'h0);
         prev_valid = 1'b0;
         prev_err   = 1'b0;
      end else begin
         if (!bus.data_valid) chk("id_zero_when_invalid", bus.chip_id, 64'h0);
         if ((bus.data_valid && !prev_valid) || (bus.id_error && !prev_err)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 64'h1, 64'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("result_chip_id", bus.chip_id, mon_e.id);
               chk("result_valid", {63'h0, bus.data_valid}, {63'h0, ~mon_e.fail});
               chk("result_error", {63'h0, bus.id_error}, {63'h0, mon_e.fail});
               chk("result_edge", 64'(edge_n), 64'(mon_e.edge_n));
            end
            resolved++;
         end
         prev_valid = bus.data_valid;
         prev_err   = bus.id_error;
      end
   end

   // Reference: outcome from the pass values and the read/compare/retry rules
   function automatic void model(output exp_t e, output int npass);
`ifdef CHIP_ID_DOUBLE_READ_EN
      e.fail   = 1'b1;
      e.id     = 64'h0;
      npass    = 2 * (MR + 1);
      e.edge_n = 1 + (MR + 1) * (2 * PASS_CYC + 1);
      for (int r = MR; r >= 0; r--) begin
         if (pass_vals[2 * r] == pass_vals[2 * r + 1]) begin
            e.fail   = 1'b0;
            e.id     = pass_vals[2 * r];
            npass    = 2 * (r + 1);
            e.edge_n = 1 + (r + 1) * (2 * PASS_CYC + 1);
         end
      end
`else
      e.fail   = 1'b0;
      e.id     = pass_vals[0];
      npass    = 1;
      e.edge_n = 1 + PASS_CYC;
`endif
   endfunction

   task automatic set_all(input logic [63:0] v);
      for (int i = 0; i < 16; i++) pass_vals[i] = v;
   endtask

   task automatic run(input string tag, input int abort_at);
      exp_t e;
      int   npass;
      int   target;
      model(e, npass);
      reset = 1'b1;
      repeat (3) @(negedge clkin);
      exp_q.delete();
      reset = 1'b0;
      exp_q.push_back(e);
      if (abort_at > 0) begin
         for (int i = 0; i < 1000 && edge_n != abort_at; i++) @(negedge clkin);
         chk("abort_point_reached", 64'(edge_n), 64'(abort_at));
         reset = 1'b1;
         repeat (3) @(negedge clkin);
         exp_q.delete();
         reset = 1'b0;
         exp_q.push_back(e);
      end
      target = resolved + 1;
      for (int i = 0; i < 3000 && resolved < target; i++) @(negedge clkin);
      if (resolved < target) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: no result within budget", tag);
      end
      repeat (10) @(negedge clkin);
      chk("load_pulses", 64'(load_pulses), 64'(npass * LP));
      chk("shift_pulses", 64'(shift_pulses), 64'(npass * 64));
      chk("idle_fuse_lines", {62'h0, bus.fuse_clk_o, bus.fuse_shiftnld_o}, 64'h0);
      chk("final_chip_id", bus.chip_id, e.id);
      chk("final_flags", {62'h0, bus.data_valid, bus.id_error}, {62'h0, ~e.fail, e.fail});
   endtask

   initial begin
      logic [63:0] v;
      #1 reset = 1'b1;
      set_all(64'h0123_4567_89AB_CDEF);
      run("fixed_id", 0);
      set_all({$urandom, $urandom});
      run("abort_at_70", 70);
      set_all(64'hFFFF_FFFF_FFFF_FFFF);
      run("all_ones", 0);
      set_all(64'h8000_0000_0000_0001);
      run("end_bits", 0);
      for (int n = 0; n < 3; n++) begin
         set_all({$urandom, $urandom});
         run("random_id", 0);
      end
`ifdef CHIP_ID_DOUBLE_READ_EN
      set_all(64'hFFFF_0000_AAAA_5555);
      run("double_stable", 0);
      v = 64'h0123_4567_89AB_CDEF;
      set_all(v);
      pass_vals[0] = v ^ 64'h8000_0000_0000_0000;
      run("double_one_retry", 0);
      for (int i = 0; i < 16; i++) pass_vals[i] = 64'(i % 2);
      run("double_fail", 0);
      v = {$urandom, $urandom};
      set_all(v);
      pass_vals[3] = v ^ (64'h1 << $urandom_range(63, 0));
      run("double_random_retry", 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
